// File: rtl/tx_block_gearbox_if.sv
// Block-in / lane-word-out bus of the TX block gearbox.
// TX_SH_ERR_INJ_EN adds the header error-injection request and its counter.
interface tx_block_gearbox_if #(
    parameter int unsigned NB_CODED_BLOCK = 66,
    parameter int unsigned NB_DATA_OUT    = NB_CODED_BLOCK - 2,
    parameter int unsigned NB_SEQ         = $clog2(NB_DATA_OUT / 2 + 1)
);
    logic                      i_valid;
    logic [NB_CODED_BLOCK-1:0] i_block;
    logic                      o_ready;
    logic                      o_valid;
    logic [NB_DATA_OUT-1:0]    o_data;
    logic [NB_SEQ-1:0]         o_sh_offset;
    logic [NB_SEQ-1:0]         o_seq;
`ifdef TX_SH_ERR_INJ_EN
    logic                      i_inj_err;
    logic [15:0]               o_inj_count;

    modport master (
        output i_valid, i_block, i_inj_err,
        input  o_ready, o_valid, o_data, o_sh_offset, o_seq, o_inj_count
    );
    modport slave (
        input  i_valid, i_block, i_inj_err,
        output o_ready, o_valid, o_data, o_sh_offset, o_seq, o_inj_count
    );
`else
    modport master (
        output i_valid, i_block,
        input  o_ready, o_valid, o_data, o_sh_offset, o_seq
    );
    modport slave (
        input  i_valid, i_block,
        output o_ready, o_valid, o_data, o_sh_offset, o_seq
    );
`endif
endinterface

// File: rtl/tx_block_gearbox.sv
// 66b -> 64b TX gearbox: 32 coded blocks per 33 lane words, header rotating 2 bits per block.
// Optional header error injection under TX_SH_ERR_INJ_EN.
module tx_block_gearbox #(
    parameter int unsigned NB_CODED_BLOCK = 66,
    parameter int unsigned NB_DATA_OUT    = NB_CODED_BLOCK - 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    tx_block_gearbox_if.slave  bus
);
    localparam int unsigned N_SEQ  = NB_DATA_OUT / 2 + 1;
    localparam int unsigned NB_SEQ = $clog2(N_SEQ);
    localparam int unsigned NB_SH  = NB_SEQ + 1;

    localparam logic [NB_SEQ-1:0] SEQ_FLUSH   = NB_SEQ'(N_SEQ - 1);
    localparam logic [NB_SEQ-1:0] SH_OFF_NONE = '1;

    logic [NB_SEQ-1:0]         seq_q,    seq_d;
    logic [NB_DATA_OUT-1:0]    res_q,    res_d;
    logic [NB_DATA_OUT-1:0]    data_q,   data_d;
    logic                      valid_q,  valid_d;
    logic [NB_SEQ-1:0]         sh_off_q, sh_off_d;

    logic                      inj_c;
    logic [1:0]                hdr_c;
    logic [NB_CODED_BLOCK-1:0] blk_eff_c;
    logic [NB_CODED_BLOCK-1:0] blk_hi_c;
    logic [NB_CODED_BLOCK-1:0] blk_lo_c;
    logic [NB_SH-1:0]          two_k_c;

`ifdef TX_SH_ERR_INJ_EN
    logic [15:0] inj_cnt_q, inj_cnt_d;
`endif

    // Block with optional header corruption, split into the part that fills the
    // current word and the part that becomes the new left-aligned residue.
    always_comb begin
        inj_c = 1'b0;
`ifdef TX_SH_ERR_INJ_EN
        inj_c = bus.i_inj_err;
`endif
        hdr_c     = bus.i_block[NB_CODED_BLOCK-1 -: 2];
        blk_eff_c = bus.i_block;
        if (inj_c) begin
            blk_eff_c[NB_CODED_BLOCK-1 -: 2] = (hdr_c == 2'b01) ? 2'b00 : 2'b11;
        end
        two_k_c  = {seq_q, 1'b0};
        blk_hi_c = blk_eff_c >> (two_k_c + NB_SH'(2));
        blk_lo_c = blk_eff_c << (NB_SH'(NB_DATA_OUT - 2) - two_k_c);
    end

    assign bus.o_ready = i_enable && (seq_q < SEQ_FLUSH);

    // Next-state: accept, flush, bubble or recovery from an unreachable step.
    always_comb begin
        seq_d    = seq_q;
        res_d    = res_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        sh_off_d = sh_off_q;
`ifdef TX_SH_ERR_INJ_EN
        inj_cnt_d = inj_cnt_q;
`endif
        if (i_enable) begin
            if (seq_q == SEQ_FLUSH) begin
                data_d   = res_q;
                res_d    = '0;
                valid_d  = 1'b1;
                sh_off_d = SH_OFF_NONE;
                seq_d    = '0;
            end else if (seq_q > SEQ_FLUSH) begin
                seq_d = '0;
            end else if (bus.i_valid) begin
                data_d   = res_q | NB_DATA_OUT'(blk_hi_c);
                res_d    = NB_DATA_OUT'(blk_lo_c);
                valid_d  = 1'b1;
                sh_off_d = NB_SEQ'(two_k_c);
                seq_d    = seq_q + NB_SEQ'(1);
`ifdef TX_SH_ERR_INJ_EN
                if (inj_c && (inj_cnt_q != 16'hffff)) begin
                    inj_cnt_d = inj_cnt_q + 16'd1;
                end
`endif
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            seq_q    <= '0;
            res_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            sh_off_q <= '0;
`ifdef TX_SH_ERR_INJ_EN
            inj_cnt_q <= '0;
`endif
        end else begin
            seq_q    <= seq_d;
            res_q    <= res_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            sh_off_q <= sh_off_d;
`ifdef TX_SH_ERR_INJ_EN
            inj_cnt_q <= inj_cnt_d;
`endif
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_data      = data_q;
    assign bus.o_sh_offset = sh_off_q;
    assign bus.o_seq       = seq_q;
`ifdef TX_SH_ERR_INJ_EN
    assign bus.o_inj_count = inj_cnt_q;
`endif

endmodule

// File: tb/tb_tx_block_gearbox.sv
// Directed bench for tx_block_gearbox: bit-stream scoreboard plus hand-computed words.
module tb_tx_block_gearbox;
    logic i_clock;
    logic i_reset;
    logic i_enable;

    tx_block_gearbox_if bus ();

    tx_block_gearbox dut (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .bus      (bus)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_k    = 0;
    bit          stream_q[$];
    logic [63:0] last_word = '0;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [65:0] mk_block(input logic [1:0] hdr, input int j);
        logic [7:0] b;
        b = 8'(j);
        return {hdr, {8{b}}};
    endfunction

    // One enabled/disabled cycle; scoreboard predicts acceptance, word, offset and step.
    task automatic cycle(input logic en_v, input logic v, input logic [65:0] blk, input logic inj,
                         output logic accepted);
        logic [65:0] eff;
        logic [63:0] w;
        logic        exp_valid;
        int          exp_off;
        i_enable    = en_v;
        bus.i_valid = v;
        bus.i_block = blk;
`ifdef TX_SH_ERR_INJ_EN
        bus.i_inj_err = inj;
`endif
        #1;
        check_value("o_ready", 128'(bus.o_ready), 128'(en_v && (exp_k != 32)));
        accepted  = 1'b0;
        exp_valid = 1'b0;
        exp_off   = 0;
        w         = '0;
        if (en_v && exp_k == 32) begin
            for (int b = 63; b >= 0; b--) w[b] = stream_q.pop_front();
            exp_valid = 1'b1;
            exp_off   = 63;
            exp_k     = 0;
        end else if (en_v && v) begin
            eff = blk;
`ifdef TX_SH_ERR_INJ_EN
            if (inj) eff[65:64] = (blk[65:64] == 2'b01) ? 2'b00 : 2'b11;
`endif
            for (int b = 65; b >= 0; b--) stream_q.push_back(eff[b]);
            for (int b = 63; b >= 0; b--) w[b] = stream_q.pop_front();
            exp_valid = 1'b1;
            exp_off   = 2 * exp_k;
            exp_k     = exp_k + 1;
            accepted  = 1'b1;
        end
        @(posedge i_clock);
        #1;
        check_value("o_valid", 128'(bus.o_valid), 128'(exp_valid));
        check_value("o_seq", 128'(bus.o_seq), 128'(exp_k));
        if (exp_valid) begin
            check_value("o_data", 128'(bus.o_data), 128'(w));
            check_value("o_sh_offset", 128'(bus.o_sh_offset), 128'(exp_off));
            last_word = w;
        end else begin
            check_value("o_data_hold", 128'(bus.o_data), 128'(last_word));
        end
    endtask

    task automatic send(input logic [65:0] blk, input logic inj);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 3 && !acc; t++) cycle(1'b1, 1'b1, blk, inj, acc);
        check_value("send_accepted", 128'(acc), 128'(1));
    endtask

    task automatic do_reset();
        i_reset     = 1'b1;
        i_enable    = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_block = '1;
        @(posedge i_clock);
        #1;
        i_reset     = 1'b0;
        bus.i_valid = 1'b0;
        stream_q.delete();
        exp_k     = 0;
        last_word = '0;
        check_value("rst_o_valid", 128'(bus.o_valid), 128'(0));
        check_value("rst_o_seq", 128'(bus.o_seq), 128'(0));
        check_value("rst_o_data", 128'(bus.o_data), 128'(0));
        check_value("rst_o_sh_offset", 128'(bus.o_sh_offset), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        i_reset     = 1'b1;
        i_enable    = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_block = '0;
`ifdef TX_SH_ERR_INJ_EN
        bus.i_inj_err = 1'b0;
`endif
        @(posedge i_clock);
        #1;
        do_reset();

        // Full sequence with continuous valid; block 32 is held through the flush.
        send(mk_block(2'b01, 0), 1'b0);
        check_value("word0", 128'(bus.o_data), 128'(64'h4000_0000_0000_0000));
        send(mk_block(2'b01, 1), 1'b0);
        check_value("word1", 128'(bus.o_data), 128'(64'h1010_1010_1010_1010));
        check_value("word1_off", 128'(bus.o_sh_offset), 128'(2));
        for (int j = 2; j < 32; j++) send(mk_block(2'b01, j), 1'b0);
        check_value("word31_off", 128'(bus.o_sh_offset), 128'(62));
        cycle(1'b1, 1'b1, mk_block(2'b01, 32), 1'b0, acc);
        check_value("flush_word", 128'(bus.o_data), 128'(64'h1f1f_1f1f_1f1f_1f1f));
        check_value("flush_off", 128'(bus.o_sh_offset), 128'(6'h3f));
        check_value("flush_seq", 128'(bus.o_seq), 128'(0));
        send(mk_block(2'b01, 32), 1'b0);
        check_value("after_flush_word", 128'(bus.o_data), 128'(64'h4808_0808_0808_0808));
        check_value("after_flush_off", 128'(bus.o_sh_offset), 128'(0));

        // Enable-low hold at k=5, bubble at k=10, reset at k=17.
        do_reset();
        for (int j = 0; j < 5; j++) send(mk_block(2'b10, j + 40), 1'b0);
        for (int c = 0; c < 5; c++) cycle(1'b0, 1'b1, mk_block(2'b10, 99), 1'b0, acc);
        check_value("en_low_seq", 128'(bus.o_seq), 128'(5));
        for (int j = 5; j < 10; j++) send(mk_block(2'b10, j + 40), 1'b0);
        for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0, mk_block(2'b11, 77), 1'b0, acc);
        check_value("bubble_seq", 128'(bus.o_seq), 128'(10));
        for (int j = 10; j < 17; j++) send(mk_block(2'b10, j + 40), 1'b0);
        check_value("pre_reset_seq", 128'(bus.o_seq), 128'(17));
        do_reset();
        send({2'b10, 64'hDEAD_BEEF_0123_4567}, 1'b0);
        check_value("post_reset_word", 128'(bus.o_data), 128'(64'hB7AB_6FBB_C048_D159));
        check_value("post_reset_off", 128'(bus.o_sh_offset), 128'(0));
        for (int j = 1; j < 32; j++) send(mk_block(2'b00, j + 100), 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, acc);

`ifdef TX_SH_ERR_INJ_EN
        // Header corruption on blocks 3 (01 -> 00) and 4 (10 -> 11).
        do_reset();
        check_value("inj_cnt_rst", 128'(bus.o_inj_count), 128'(0));
        send(mk_block(2'b01, 0), 1'b0);
        send(mk_block(2'b01, 1), 1'b0);
        send(mk_block(2'b01, 2), 1'b0);
        check_value("hdr2", 128'(bus.o_data[59:58]), 128'(2'b01));
        send(mk_block(2'b01, 3), 1'b1);
        check_value("hdr3_inj", 128'(bus.o_data[57:56]), 128'(2'b00));
        send(mk_block(2'b10, 4), 1'b1);
        check_value("hdr4_inj", 128'(bus.o_data[55:54]), 128'(2'b11));
        check_value("inj_cnt", 128'(bus.o_inj_count), 128'(2));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tx_block_gearbox.md
Name: tx_block_gearbox

Overview:
- Transmit-side counterpart of the receive block-sync logic.
- Accepts 66-bit coded blocks (2-bit sync header + 64-bit payload) and serialises them into a continuous 64-bit-wide lane stream.
- Sync header position rotates by 2 bits per block, which is the pattern the receive block-lock FSM searches for.
- Sits between the TX scrambler/encoder output and the PMA/lane interface.

Parameters:
- NB_CODED_BLOCK, 66, coded block width; header in bits [65:64], transmitted first (MSB-first).
- NB_DATA_OUT, 64, output word width; must equal NB_CODED_BLOCK-2.
- N_SEQ, NB_DATA_OUT/2+1 (33), gearbox sequence length: 32 input blocks per 33 output words.
- NB_SEQ, $clog2(N_SEQ) (6), sequence counter width.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  global enable; when low all state holds.
- i_valid  in  1  i_block valid.
- i_block  in  NB_CODED_BLOCK  coded block, [65:64]=sync header.
- i_inj_err  in  1  header error injection request (present only with TX_SH_ERR_INJ_EN).
- o_ready  out  1  block will be accepted this cycle if i_valid.
- o_valid  out  1  o_data valid.
- o_data  out  NB_DATA_OUT  lane word, bit [63] transmitted first.
- o_sh_offset  out  NB_SEQ  bit offset (from MSB) of the sync header inside o_data; 0..62 even; 63 (all ones) when the word contains no header (flush word).
- o_seq  out  NB_SEQ  current sequence step k, 0..32.

Behaviour:
- State registers: seq k (0..32) and residue (64 bits, holding 2k valid bits left-aligned).
- o_ready = i_enable && (k != 32). Combinational from the registered k.
- Accept condition: i_enable && i_valid && o_ready. When it holds at step k (0..31), on the next edge:
  - o_data = {residue[63:64-2k], i_block[65:2k+2]}.
  - residue <= i_block[2k+1:0], left-aligned.
  - o_valid <= 1, o_sh_offset <= 2k, k <= k+1.
- Flush step, k==32 and i_enable: on the next edge o_data <= residue (64 bits), o_valid <= 1, o_sh_offset <= 63, residue <= 0, k <= 0. i_valid is ignored.
- Bubble, k<32 and i_enable && !i_valid: o_valid <= 0; o_data, residue and k hold.
- i_enable low: all registers hold, o_valid <= 0.
- Latency: one cycle from acceptance or flush to o_valid.
- Header content is not checked; any value is passed through, including invalid 00 and 11.
- Reset, including mid-sequence: k=0, residue=0, o_data=0, o_valid=0, o_sh_offset=0. Partial residue is discarded, with no flush.
- k wraps 32→0 only via the flush step; values 33..63 are unreachable. If one occurs, force k to 0 on the next enabled edge.
- Throughput: 32 blocks per 33 enabled cycles with continuous i_valid. 32*66 = 33*64 = 2112 bits.

Optional Feature:
- Macro: TX_SH_ERR_INJ_EN.
- Defined:
  - Port i_inj_err exists.
  - On an accepted block with i_inj_err=1, the header is replaced by 2'b00 if the original is 01, otherwise by 2'b11. The payload is unchanged.
  - A 16-bit saturating output o_inj_count counts injected headers; reset to 0.
  - Used to drive the receive invalid-header counter and unlock path.
- Undefined: no i_inj_err or o_inj_count ports; headers pass unmodified.

Test Plan:
- Continuous i_valid, 32 blocks {2'b01, 64'hk-patterned} -> 33 o_valid words; o_sh_offset = 0,2,...,62,63; o_ready low only at k=32; concatenated output bits equal concatenated input blocks.
- i_valid dropped for 3 cycles at k=10 -> o_valid low for 3 cycles, k stays 10, output bit stream unchanged vs. run with no bubble.
- i_valid=1 at k=32 -> block not accepted (o_ready=0), flush word emitted, same block accepted at k=0 next cycle.
- i_reset asserted at k=17 -> next cycle o_valid=0, o_seq=0, o_data=0; following block emitted with o_sh_offset=0 and no stale residue bits.
- i_enable low for 5 cycles at k=5 with i_valid high -> no acceptance, o_valid=0, state held; resumes at k=5.
- With TX_SH_ERR_INJ_EN, i_inj_err=1 on blocks 3 and 4 with headers 01 and 10 -> emitted headers 00 and 11 at offsets 6 and 8; o_inj_count=2.
